// File: rtl/mxn_scan.sv
// Registered N-channel, W-bit multiplexer with a manual select mode and a
// masked scan mode that presents one channel per beat on a valid/ready handshake.
module mxn_scan #(
   parameter int WIDTH = 4,
   parameter int CH    = 8,
   parameter int SW    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CH*WIDTH-1:0]   d,
   input  logic                  mode,
   input  logic [SW-1:0]         sel,
   input  logic                  en,
   input  logic [CH-1:0]         mask,
   input  logic                  start,
   input  logic                  y_ready,
   output logic [WIDTH-1:0]      y,
   output logic [SW-1:0]         y_ch,
   output logic                  y_valid,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, MAN, SCAN, FIN} state_t;

   state_t          state;
   logic [CH-1:0]   scan_mask;   // latched mask with already-served channels cleared
   logic [SW-1:0]   nxt;
   logic [CH-1:0]   nxt_onehot;

   // Channel select; an index at or beyond CH yields zero.
   function automatic logic [WIDTH-1:0] pick(input logic [SW-1:0] s,
                                             input logic [CH*WIDTH-1:0] data);
      pick = '0;
      for (int k = 0; k < CH; k++)
         if (s == SW'(k)) pick = data[k*WIDTH +: WIDTH];
   endfunction

   // Lowest set bit wins, so cleared channels cost no extra cycle.
   function automatic logic [SW-1:0] first_set(input logic [CH-1:0] m);
      first_set = '0;
      for (int k = CH-1; k >= 0; k--)
         if (m[k]) first_set = SW'(k);
   endfunction

   always_comb begin
      nxt        = first_set(scan_mask);
      nxt_onehot = '0;
      for (int k = 0; k < CH; k++)
         if (nxt == SW'(k)) nxt_onehot[k] = 1'b1;
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // branch below reads the values from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         scan_mask <= '0;
         y         <= '0;
         y_ch      <= '0;
         y_valid   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               y_valid <= 1'b0;
               if (!mode && en) begin
                  y       <= pick(sel, d);
                  y_ch    <= sel;
                  y_valid <= 1'b1;
                  busy    <= 1'b1;
                  state   <= MAN;
               end else if (mode && start) begin
                  scan_mask <= mask;
                  busy      <= 1'b1;
                  state     <= SCAN;
               end
            end
            MAN: begin
               if (en) begin
                  y       <= pick(sel, d);
                  y_ch    <= sel;
                  y_valid <= 1'b1;
               end else begin
                  y_valid <= 1'b0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            SCAN: begin
               // A stalled beat holds; otherwise load the next channel or finish.
               if (!y_valid || y_ready) begin
                  if (scan_mask != '0) begin
                     y         <= pick(nxt, d);
                     y_ch      <= nxt;
                     y_valid   <= 1'b1;
                     scan_mask <= scan_mask & ~nxt_onehot;
                  end else begin
                     y_valid <= 1'b0;
                     done    <= 1'b1;
                     state   <= FIN;
                  end
               end
            end
            FIN: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mxn_scan.sv
// Directed bench for mxn_scan: reset, manual select, full and sparse scans,
// backpressure, empty mask, ignored inputs and reset in the middle of a scan.
module tb_mxn_scan;

   localparam int WIDTH = 4;
   localparam int CH    = 8;
   localparam int SW    = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic [CH*WIDTH-1:0] d;
   logic                mode;
   logic [SW-1:0]       sel;
   logic                en;
   logic [CH-1:0]       mask;
   logic                start;
   logic                y_ready;
   logic [WIDTH-1:0]    y;
   logic [SW-1:0]       y_ch;
   logic                y_valid;
   logic                busy;
   logic                done;

   int checks = 0;
   int errors = 0;

   mxn_scan #(.WIDTH(WIDTH), .CH(CH), .SW(SW)) dut (
      .clk(clk), .rst(rst), .d(d), .mode(mode), .sel(sel), .en(en),
      .mask(mask), .start(start), .y_ready(y_ready), .y(y), .y_ch(y_ch),
      .y_valid(y_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Observed tuple order: {y, y_ch, y_valid, busy, done}
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; d = 32'h8_7_A_5_4_3_2_1; mode = 1'b0; sel = 3'd5; en = 1'b1;
      mask = '0; start = 1'b0; y_ready = 1'b1;
      #2;
      checks++;
      if ({y, y_ch, y_valid, busy, done} !== {4'h0, 3'd0, 3'b000}) begin
         errors++;
         $display("FAIL reset_initial got %h/%0d/%b%b%b want 0/0/000", y, y_ch, y_valid, busy, done);
      end
      step();
      rst = 1'b0;
      step();
      checks++;
      if ({y, y_valid} !== {4'hA, 1'b1}) begin
         errors++;
         $display("FAIL reset_pre_activity got y=%h v=%b want A/1", y, y_valid);
      end
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({y, y_ch, y_valid, busy, done} !== {4'h0, 3'd0, 3'b000}) begin
         errors++;
         $display("FAIL reset_async got %h/%0d/%b%b%b want 0/0/000", y, y_ch, y_valid, busy, done);
      end
      step();
      rst = 1'b0; en = 1'b0;
      step();
   endtask

   task automatic test_manual();
      d = 32'h8_7_A_5_4_3_2_1; mode = 1'b0; sel = 3'd5; en = 1'b1;
      step();
      checks++;
      if ({y, y_ch, y_valid, busy, done} !== {4'hA, 3'd5, 3'b110}) begin
         errors++;
         $display("FAIL manual_ch5 got %h/%0d/%b%b%b want A/5/110", y, y_ch, y_valid, busy, done);
      end
      sel = 3'd7;
      step();
      checks++;
      if ({y, y_ch, y_valid} !== {4'h8, 3'd7, 1'b1}) begin
         errors++;
         $display("FAIL manual_ch7 got %h/%0d/%b want 8/7/1", y, y_ch, y_valid);
      end
      sel = 3'd0;
      step();
      checks++;
      if ({y, y_ch, y_valid} !== {4'h1, 3'd0, 1'b1}) begin
         errors++;
         $display("FAIL manual_ch0 got %h/%0d/%b want 1/0/1", y, y_ch, y_valid);
      end
      en = 1'b0;
      step();
      checks++;
      if ({y_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL manual_release got v/b/d=%b%b%b want 000", y_valid, busy, done);
      end
   endtask

   task automatic test_full_scan();
      d = 32'h8765_4321; mode = 1'b1; mask = 8'hFF; start = 1'b1; y_ready = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if ({y_valid, busy, done} !== 3'b010) begin
         errors++;
         $display("FAIL full_start got v/b/d=%b%b%b want 010", y_valid, busy, done);
      end
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if ({y, y_ch, y_valid, busy, done} !== {4'(i + 1), 3'(i), 3'b110}) begin
            errors++;
            $display("FAIL full_beat%0d got %h/%0d/%b%b%b want %0h/%0d/110",
                     i, y, y_ch, y_valid, busy, done, i + 1, i);
         end
      end
      step();
      checks++;
      if ({y_valid, busy, done} !== 3'b011) begin
         errors++;
         $display("FAIL full_done got v/b/d=%b%b%b want 011", y_valid, busy, done);
      end
      step();
      checks++;
      if ({y_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL full_idle got v/b/d=%b%b%b want 000", y_valid, busy, done);
      end
   endtask

   task automatic test_backpressure();
      d = 32'h8765_4321; mode = 1'b1; mask = 8'b1010_0100; start = 1'b1; y_ready = 1'b0;
      step();
      start = 1'b0;
      step();
      checks++;
      if ({y, y_ch, y_valid} !== {4'h3, 3'd2, 1'b1}) begin
         errors++;
         $display("FAIL bp_first got %h/%0d/%b want 3/2/1", y, y_ch, y_valid);
      end
      d[2*WIDTH +: WIDTH] = 4'hF;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({y, y_ch, y_valid, done} !== {4'h3, 3'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold%0d got %h/%0d/%b/%b want 3/2/1/0", i, y, y_ch, y_valid, done);
         end
      end
      y_ready = 1'b1;
      step();
      checks++;
      if ({y, y_ch, y_valid} !== {4'h6, 3'd5, 1'b1}) begin
         errors++;
         $display("FAIL bp_ch5 got %h/%0d/%b want 6/5/1", y, y_ch, y_valid);
      end
      step();
      checks++;
      if ({y, y_ch, y_valid} !== {4'h8, 3'd7, 1'b1}) begin
         errors++;
         $display("FAIL bp_ch7 got %h/%0d/%b want 8/7/1", y, y_ch, y_valid);
      end
      step();
      checks++;
      if ({y_valid, busy, done} !== 3'b011) begin
         errors++;
         $display("FAIL bp_done got v/b/d=%b%b%b want 011", y_valid, busy, done);
      end
      step();
      d = 32'h8765_4321;
   endtask

   task automatic test_empty_mask();
      mode = 1'b1; mask = '0; start = 1'b1; y_ready = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if ({y_valid, busy, done} !== 3'b010) begin
         errors++;
         $display("FAIL empty_edge1 got v/b/d=%b%b%b want 010", y_valid, busy, done);
      end
      step();
      checks++;
      if ({y_valid, busy, done} !== 3'b011) begin
         errors++;
         $display("FAIL empty_edge2 got v/b/d=%b%b%b want 011", y_valid, busy, done);
      end
      step();
      checks++;
      if ({y_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL empty_after got v/b/d=%b%b%b want 000", y_valid, busy, done);
      end
   endtask

   task automatic test_ignored_inputs();
      int beats = 0;
      int dones = 0;
      mode = 1'b1; mask = 8'b0001_1001; start = 1'b1; y_ready = 1'b1;
      step();
      mode = 1'b0; mask = 8'hFF;
      for (int i = 0; i < 6; i++) begin
         start = i[0];
         step();
         if (y_valid) beats++;
         if (done) dones++;
      end
      start = 1'b0;
      step();
      step();
      checks++;
      if ({beats, dones} !== {32'd3, 32'd1}) begin
         errors++;
         $display("FAIL ignored_inputs got beats=%0d dones=%0d want 3/1", beats, dones);
      end
      checks++;
      if ({y_ch, y_valid, busy, done} !== {3'd4, 3'b000}) begin
         errors++;
         $display("FAIL ignored_final got ch=%0d v/b/d=%b%b%b want 4/000", y_ch, y_valid, busy, done);
      end
   endtask

   task automatic test_reset_mid_scan();
      int dones = 0;
      mode = 1'b1; mask = 8'hFF; start = 1'b1; y_ready = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if ({y, y_ch, y_valid} !== {4'h4, 3'd3, 1'b1}) begin
         errors++;
         $display("FAIL mid_ch3 got %h/%0d/%b want 4/3/1", y, y_ch, y_valid);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({y, y_ch, y_valid, busy, done} !== {4'h0, 3'd0, 3'b000}) begin
         errors++;
         $display("FAIL mid_reset got %h/%0d/%b%b%b want 0/0/000", y, y_ch, y_valid, busy, done);
      end
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (done || busy) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL mid_no_done got %0d busy/done cycles want 0", dones);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      checks++;
      if ({y, y_ch, y_valid} !== {4'h1, 3'd0, 1'b1}) begin
         errors++;
         $display("FAIL mid_restart got %h/%0d/%b want 1/0/1", y, y_ch, y_valid);
      end
   endtask

   initial begin
      test_reset();
      test_manual();
      test_full_scan();
      test_backpressure();
      test_empty_mask();
      test_ignored_inputs();
      test_reset_mid_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mxn_scan.md
Name: mxn_scan

Overview:
- Parametrised, registered N-channel, W-bit multiplexer; the next generation of the 2:1/8:1 mux tree blocks used in the ALU datapath.
- Two modes: manual select (registered mux, one-cycle latency) and scan, a state-machine sweep over masked channels.
- In scan mode the block presents one channel per beat on a valid/ready output handshake.
- Feeds the ALU result bus or a display/debug serialiser; downstream logic may stall it.

Parameters:
- WIDTH, 4, bit width of each channel.
- CH, 8, number of input channels (>=2).
- SW, 3, select width; must satisfy 2**SW >= CH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- d  input  CH*WIDTH  flattened channel data; channel k = d[k*WIDTH +: WIDTH].
- mode  input  1  0 = manual, 1 = scan; sampled only in IDLE.
- sel  input  SW  manual channel select.
- en  input  1  manual-mode capture enable.
- mask  input  CH  scan channel enable mask; bit k set = include channel k; latched at start.
- start  input  1  scan start pulse; honoured only in IDLE with mode=1.
- y_ready  input  1  downstream ready.
- y  output  WIDTH  registered selected data.
- y_ch  output  SW  channel index of y.
- y_valid  output  1  y/y_ch valid.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse at end of scan.

Behaviour:
- Reset (async, any state): y=0, y_ch=0, y_valid=0, busy=0, done=0, state=IDLE, latched mask=0, scan pointer=0.
- State machine: IDLE, MAN, SCAN, FIN.
- IDLE:
  - mode=0 and en=1: go to MAN, performing the MAN capture in the same edge.
  - mode=1 and start=1: latch mask, pointer=0, go to SCAN.
  - otherwise y_valid=0.
- MAN:
  - Each edge with en=1: y<=d[sel], y_ch<=sel, y_valid<=1.
  - sel>=CH: y<=0, y_ch<=sel, y_valid<=1.
  - en=0: y_valid<=0, return to IDLE.
  - MAN ignores y_ready; there is no backpressure in manual mode.
  - Latency is 1 cycle from sel/d to y.
- SCAN:
  - Pointer advances to the next set mask bit at or after its current value.
  - When a beat is presented: y<=d[ptr], y_ch<=ptr, y_valid<=1.
  - Handshake: a beat completes on an edge with y_valid && y_ready.
  - While y_valid && !y_ready: y, y_ch and y_valid hold stable. Input d changes are ignored for the held beat; d is sampled when the beat is loaded.
  - Back-to-back: with y_ready held high, one beat per cycle; consecutive set bits produce beats in consecutive cycles. Cleared bits are skipped with zero-cycle penalty, using a priority search in one cycle.
  - After the beat for the highest set bit completes, go to FIN with y_valid<=0.
- FIN: done=1 for exactly one cycle, then IDLE. busy=0 in IDLE only.
- mask==0 at start: SCAN yields no beats; FIN is reached the cycle after start, so done pulses at start+2 edges.
- start while busy: ignored. mode or mask changes during a scan: ignored, because the latched mask is used.
- Reset mid-scan: immediate return to reset values; no done pulse.
- Width rule: y_ch is zero-extended channel index in SW bits; no arithmetic wrap, since the pointer never exceeds CH-1.

Test Plan:
- Reset/manual:
  - Stimulus: assert rst mid-activity. Required: all outputs 0 immediately, without waiting for a clock edge.
  - Stimulus: release rst; mode=0, en=1, d ch5=4'hA, sel=5. Required: next edge y=A, y_ch=5, y_valid=1.
  - Stimulus: sel=7 then 0 on consecutive cycles. Required: y follows with 1-cycle latency.
- Full scan:
  - Stimulus: CH=8, channel k=k+1, mask=8'hFF, start, y_ready=1.
  - Required: 8 consecutive beats y=1..8, y_ch=0..7; done pulses one cycle after last beat; busy falls with done.
- Sparse mask with backpressure:
  - Stimulus: mask=8'b1010_0100; y_ready low 3 cycles on the first beat.
  - Required: beats ch2, ch5, ch7 only; ch2 beat holds y/y_ch stable for 3 extra cycles; d changes during the stall are not reflected.
- Empty mask:
  - Stimulus: mask=0, start.
  - Required: y_valid never asserts; done pulses exactly once, 2 edges after start.
- Ignored inputs and reset mid-scan:
  - Stimulus: start and mode toggles while busy. Required: no effect.
  - Stimulus: rst asserted mid-scan at the ch3 beat. Required: outputs 0 immediately; no done pulse; a fresh start afterwards scans from ch0.
